// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: segment bit order,
// the dark pattern and the active-low hex decode table.
package seg_pkg;

    localparam int unsigned SEG_A_BIT  = 7;
    localparam int unsigned SEG_B_BIT  = 6;
    localparam int unsigned SEG_C_BIT  = 5;
    localparam int unsigned SEG_D_BIT  = 4;
    localparam int unsigned SEG_E_BIT  = 3;
    localparam int unsigned SEG_F_BIT  = 2;
    localparam int unsigned SEG_G_BIT  = 1;
    localparam int unsigned SEG_DP_BIT = 0;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {a..g, dp}; dp is dark in every entry and patched in later.
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low a..g segment decoder.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    logic [7:0] entry;

    always_comb begin
        entry = SEG_TABLE[nibble_i];
        seg_o = entry[SEG_A_BIT:SEG_G_BIT];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: prescaler, digit index, blink phase and
// registered anode/cathode outputs, with leading-zero suppression.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS    = 8,
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 64
) (
    input  logic                  cp,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  lz_suppress,
    output logic [DIGITS-1:0]     anodes,
    output logic [7:0]            cathnodes,
    output logic                  frame_tick
);

    localparam int unsigned PCNT_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = $clog2(DIGITS);
    localparam int unsigned FCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              bphase_q, bphase_d;
    logic [DIGITS-1:0] anodes_q, anodes_d;
    logic [7:0]        cath_q, cath_d;
    logic              ftick_q, ftick_d;

    logic              slot;
    logic [IDX_W-1:0]  idx_nxt;
    logic [3:0]        nib_sel;
    logic [6:0]        seg_sel;
    logic              any_nz;
    logic              off;
    logic              lz;
    logic [7:0]        pattern;

    assign slot    = en && (pcnt_q == PCNT_W'(SCAN_DIV - 1));
    assign idx_nxt = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    assign nib_sel = value[{idx_nxt, 2'b00} +: 4];

    seg_hex_decode u_decode (
        .nibble_i (nib_sel),
        .seg_o    (seg_sel)
    );

    // Pattern for the digit about to be selected, built from this cycle's inputs.
    always_comb begin
        any_nz = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (k >= int'(idx_nxt) && value[4*k +: 4] != 4'h0) begin
                any_nz = 1'b1;
            end
        end
        off = blank[idx_nxt] || (blink[idx_nxt] && bphase_q);
        lz  = lz_suppress && (idx_nxt != '0) && !any_nz;
        if (off) begin
            pattern = SEG_OFF;
        end else if (lz) begin
            pattern = SEG_OFF;
            pattern[SEG_DP_BIT] = ~dp[idx_nxt];
        end else begin
            pattern = {seg_sel, 1'b1};
            pattern[SEG_DP_BIT] = ~dp[idx_nxt];
        end
    end

    always_comb begin
        pcnt_d   = pcnt_q;
        idx_d    = idx_q;
        fcnt_d   = fcnt_q;
        bphase_d = bphase_q;
        anodes_d = anodes_q;
        cath_d   = cath_q;
        ftick_d  = 1'b0;
        if (!en) begin
            anodes_d = '1;
            cath_d   = SEG_OFF;
        end else begin
            pcnt_d = slot ? '0 : pcnt_q + PCNT_W'(1);
            if (slot) begin
                idx_d    = idx_nxt;
                anodes_d = ~(DIGITS'(1) << idx_nxt);
                cath_d   = pattern;
                if (idx_nxt == '0) begin
                    ftick_d = 1'b1;
                    if (fcnt_q == FCNT_W'(BLINK_DIV - 1)) begin
                        fcnt_d   = '0;
                        bphase_d = ~bphase_q;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge cp) begin
        if (rst) begin
            pcnt_q   <= '0;
            idx_q    <= IDX_W'(DIGITS - 1);
            fcnt_q   <= '0;
            bphase_q <= 1'b0;
            anodes_q <= '1;
            cath_q   <= SEG_OFF;
            ftick_q  <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            fcnt_q   <= fcnt_d;
            bphase_q <= bphase_d;
            anodes_q <= anodes_d;
            cath_q   <= cath_d;
            ftick_q  <= ftick_d;
        end
    end

    assign anodes     = anodes_q;
    assign cathnodes  = cath_q;
    assign frame_tick = ftick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with DIGITS=4, SCAN_DIV=4,
// BLINK_DIV=2.
module tb_seg_scan_ctrl;

    localparam int unsigned DIGITS    = 4;
    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned BLINK_DIV = 2;

    localparam logic [3:0] EXP_AN_1234 [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    localparam logic [7:0] EXP_CA_1234 [4] = '{8'h99, 8'h0D, 8'h25, 8'h9F};
    localparam logic [7:0] EXP_CA_LZ   [4] = '{8'h03, 8'h49, 8'hFF, 8'hFE};

    logic        cp = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic        lz_suppress;
    logic [3:0]  anodes;
    logic [7:0]  cathnodes;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    always #5 cp = ~cp;

    seg_scan_ctrl #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .cp          (cp),
        .rst         (rst),
        .en          (en),
        .value       (value),
        .dp          (dp),
        .blank       (blank),
        .blink       (blink),
        .lz_suppress (lz_suppress),
        .anodes      (anodes),
        .cathnodes   (cathnodes),
        .frame_tick  (frame_tick)
    );

    task automatic tick();
        @(posedge cp);
        #1;
    endtask

    // Leaves rst low just after an edge that sampled it high.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        value = 16'h1234; dp = '0; blank = '0; blink = '0; lz_suppress = 1'b0; en = 1'b1;
        do_reset();
        checks++;
        if (anodes !== 4'hF || cathnodes !== 8'hFF || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got an=%h ca=%h ft=%b expected an=F ca=FF ft=0",
                     anodes, cathnodes, frame_tick);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (anodes !== 4'hF || cathnodes !== 8'hFF || frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL pre_slot_dark[%0d]: got an=%h ca=%h ft=%b expected an=F ca=FF ft=0",
                         c, anodes, cathnodes, frame_tick);
            end
        end
        tick();
        checks++;
        if (anodes !== 4'hE || cathnodes !== 8'h99 || frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL first_slot: got an=%h ca=%h ft=%b expected an=E ca=99 ft=1",
                     anodes, cathnodes, frame_tick);
        end
        tick();
        checks++;
        if (anodes !== 4'hE || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_one_cycle: got an=%h ft=%b expected an=E ft=0",
                     anodes, frame_tick);
        end
    endtask

    task automatic test_full_scan();
        value = 16'h1234; dp = '0; blank = '0; blink = '0; lz_suppress = 1'b0; en = 1'b1;
        do_reset();
        repeat (3) tick();
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                checks++;
                if (anodes !== EXP_AN_1234[d] || cathnodes !== EXP_CA_1234[d]) begin
                    errors++;
                    $display("FAIL scan d%0d c%0d: got an=%h ca=%h expected an=%h ca=%h",
                             d, c, anodes, cathnodes, EXP_AN_1234[d], EXP_CA_1234[d]);
                end
            end
        end
        tick();
        checks++;
        if (anodes !== 4'hE || cathnodes !== 8'h99 || frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL scan_wrap: got an=%h ca=%h ft=%b expected an=E ca=99 ft=1",
                     anodes, cathnodes, frame_tick);
        end
    endtask

    task automatic test_lz();
        value = 16'h0050; dp = 4'b1000; blank = '0; blink = '0; lz_suppress = 1'b1; en = 1'b1;
        do_reset();
        repeat (3) tick();
        for (int d = 0; d < 4; d++) begin
            tick();
            checks++;
            if (anodes !== EXP_AN_1234[d] || cathnodes !== EXP_CA_LZ[d]) begin
                errors++;
                $display("FAIL lz d%0d: got an=%h ca=%h expected an=%h ca=%h",
                         d, anodes, cathnodes, EXP_AN_1234[d], EXP_CA_LZ[d]);
            end
            repeat (3) tick();
        end
        value = 16'h0000;
        tick();
        checks++;
        if (anodes !== 4'hE || cathnodes !== 8'h03) begin
            errors++;
            $display("FAIL lz_zero_d0: got an=%h ca=%h expected an=E ca=03", anodes, cathnodes);
        end
        repeat (4) tick();
        checks++;
        if (anodes !== 4'hD || cathnodes !== 8'hFF) begin
            errors++;
            $display("FAIL lz_zero_d1: got an=%h ca=%h expected an=D ca=FF", anodes, cathnodes);
        end
    endtask

    task automatic test_blink_blank();
        logic [7:0] exp_d0;
        value = 16'h1234; dp = '0; blank = 4'b0100; blink = 4'b0001; lz_suppress = 1'b0;
        en = 1'b1;
        do_reset();
        repeat (3) tick();
        for (int f = 0; f < 6; f++) begin
            for (int d = 0; d < 4; d++) begin
                tick();
                if (d == 0) begin
                    exp_d0 = (f == 2 || f == 3) ? 8'hFF : 8'h99;
                    checks++;
                    if (anodes !== 4'hE || cathnodes !== exp_d0 || frame_tick !== 1'b1) begin
                        errors++;
                        $display("FAIL blink f%0d: got an=%h ca=%h ft=%b expected an=E ca=%h ft=1",
                                 f, anodes, cathnodes, frame_tick, exp_d0);
                    end
                end
                if (d == 2) begin
                    checks++;
                    if (anodes !== 4'hB || cathnodes !== 8'hFF) begin
                        errors++;
                        $display("FAIL blank f%0d: got an=%h ca=%h expected an=B ca=FF",
                                 f, anodes, cathnodes);
                    end
                end
                repeat (3) tick();
            end
        end
    endtask

    task automatic test_enable();
        value = 16'h1234; dp = '0; blank = '0; blink = '0; lz_suppress = 1'b0; en = 1'b1;
        do_reset();
        repeat (3) tick();
        repeat (2) begin
            tick();
            repeat (3) tick();
        end
        tick();
        checks++;
        if (anodes !== 4'hB || cathnodes !== 8'h25) begin
            errors++;
            $display("FAIL en_pre_d2: got an=%h ca=%h expected an=B ca=25", anodes, cathnodes);
        end
        tick();
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (anodes !== 4'hF || cathnodes !== 8'hFF || frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL en_low[%0d]: got an=%h ca=%h ft=%b expected an=F ca=FF ft=0",
                         c, anodes, cathnodes, frame_tick);
            end
        end
        en = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (anodes !== 4'hF || cathnodes !== 8'hFF) begin
                errors++;
                $display("FAIL en_resume_dark[%0d]: got an=%h ca=%h expected an=F ca=FF",
                         c, anodes, cathnodes);
            end
        end
        tick();
        checks++;
        if (anodes !== 4'h7 || cathnodes !== 8'h9F) begin
            errors++;
            $display("FAIL en_resume_d3: got an=%h ca=%h expected an=7 ca=9F", anodes, cathnodes);
        end
    endtask

    // Continues from test_enable with digit 3 freshly selected.
    task automatic test_reset_mid();
        repeat (3) tick();
        tick();
        checks++;
        if (anodes !== 4'hE || frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got an=%h ft=%b expected an=E ft=1", anodes, frame_tick);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (anodes !== 4'hF || cathnodes !== 8'hFF || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got an=%h ca=%h ft=%b expected an=F ca=FF ft=0",
                     anodes, cathnodes, frame_tick);
        end
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (anodes !== 4'hF || cathnodes !== 8'hFF) begin
            errors++;
            $display("FAIL mid_restart_dark: got an=%h ca=%h expected an=F ca=FF",
                     anodes, cathnodes);
        end
        tick();
        checks++;
        if (anodes !== 4'hE || cathnodes !== 8'h99 || frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart_d0: got an=%h ca=%h ft=%b expected an=E ca=99 ft=1",
                     anodes, cathnodes, frame_tick);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; value = '0; dp = '0; blank = '0; blink = '0;
        lz_suppress = 1'b0;
        test_reset();
        test_full_scan();
        test_lz();
        test_blink_blank();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
